// File: rtl/multicycle_add_sub_pkg.sv
// Shared types and helpers for the multi-cycle adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicycle_add_sub_pkg;

    // Control FSM encoding; values are fixed so that waveforms and any
    // external decoders agree on what each code means.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter that indexes n slices; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multicycle_add_sub_chunk_adder.sv
// Purpose: combinational CHUNK-bit ripple adder slice with carry in/out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: a, b (CHUNK) operands; c_in carry in; sum (CHUNK); c_out carry out of
//        the top bit; c_msb_in carry into the top bit (used for signed overflow).
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb_in
);

    // cy[i] is the carry into bit i; cy[CHUNK] leaves the slice.
    logic [CHUNK:0] cy;

    assign cy[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ cy[i];
        assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end

    assign c_out    = cy[CHUNK];
    assign c_msb_in = cy[CHUNK-1];

endmodule

// File: rtl/multicycle_add_sub.sv
// Purpose: WIDTH-bit add/sub computed one CHUNK-bit slice per clock with a registered carry.
// Latency: start accepted at edge E0 -> done pulses in the cycle after edge E(NCHUNK+1).
// Backpressure: start is ignored (not queued) while busy=1; result held until the next accepted start.
// Ports: clk, rst (sync, active-high); start/op_sub/a/b request (sampled when idle);
//        busy, done (1-cycle pulse), result, carry_out, overflow (valid with done).
module multicycle_add_sub
    import multicycle_add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = idx_width(NCHUNK);
    localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("multicycle_add_sub: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end

    state_t                        state_q, state_d;
    // Operands and result are kept as slice arrays so the per-cycle slice is a plain index.
    logic [NCHUNK-1:0][CHUNK-1:0]  a_q, a_d;
    logic [NCHUNK-1:0][CHUNK-1:0]  b_q, b_d;
    logic [NCHUNK-1:0][CHUNK-1:0]  result_q, result_d;
    logic [CW-1:0]                 idx_q, idx_d;
    logic                          c_q, c_d;
    // Set once the last slice is written; RUN spends one more cycle before DONE.
    logic                          fin_q, fin_d;
    logic                          carry_out_q, carry_out_d;
    logic                          overflow_q, overflow_d;

    logic [CHUNK-1:0]              slice_sum;
    logic                          slice_c_out;
    logic                          slice_c_msb;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a        (a_q[idx_q]),
        .b        (b_q[idx_q]),
        .c_in     (c_q),
        .sum      (slice_sum),
        .c_out    (slice_c_out),
        .c_msb_in (slice_c_msb)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            c_q         <= 1'b0;
            fin_q       <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            c_q         <= c_d;
            fin_q       <= fin_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (fin_q) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath updates.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        idx_d       = idx_q;
        c_d         = c_q;
        fin_d       = fin_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtract as a + ~b + 1: invert B once here, seed the carry with 1.
                    a_d   = a;
                    b_d   = b ^ {WIDTH{op_sub}};
                    c_d   = op_sub;
                    idx_d = '0;
                    fin_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (!fin_q) begin
                    result_d[idx_q] = slice_sum;
                    c_d             = slice_c_out;
                    if (idx_q == LAST_IDX) begin
                        fin_d       = 1'b1;
                        carry_out_d = slice_c_out;
                        overflow_d  = slice_c_out ^ slice_c_msb;
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule
